// File: rtl/md_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
package md_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  // Zero-flag encoding shared with the combinational ALU.
  localparam logic ALU_RESULT_IS_ZERO     = 1'b1;
  localparam logic ALU_RESULT_IS_NOT_ZERO = 1'b0;

  // Fill bit used when widening an operand: sign bit if signed, zero otherwise.
  function automatic logic sext_bit(input logic msb, input logic is_signed);
    return msb & is_signed;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring divider core on unsigned magnitudes, one quotient bit per edge.
// The start edge already performs the first iteration, so q/r are complete
// WIDTH edges after start (done pulses for one cycle at that point).
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] rem_q, quo_q, den_q;

  logic [WIDTH-1:0] rem_src, quo_src, den_src, rem_nxt, quo_nxt;
  logic [WIDTH:0]   shifted, diff;
  logic             take;

  // One restoring step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    rem_src = start ? '0 : rem_q;
    quo_src = start ? a : quo_q;
    den_src = start ? b : den_q;
    shifted = {rem_src, quo_src[WIDTH-1]};
    diff    = shifted - {1'b0, den_src};
    take    = ~diff[WIDTH];
    rem_nxt = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {quo_src[WIDTH-2:0], take};
  end

  // Iteration state; start always restarts, even over a stale run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
    end else if (start) begin
      rem_q  <= rem_nxt;
      quo_q  <= quo_nxt;
      den_q  <= b;
      cnt_q  <= CW'(WIDTH - 1);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = quo_q;
  assign r    = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M multiply/divide unit with valid/ready handshake.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill,
  input  logic             in_valid,
  output logic             in_ready,
  input  md_op_t           operator,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_is_zero
);

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
  // Product stages after the operand edge; the result register is the last one.
  localparam int PD  = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;
  localparam int MCW = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;

  md_state_t        state_q, state_d;
  md_op_t           op_q;
  logic             neg_q_q, neg_r_q;
  logic [MCW-1:0]   mcnt_q, mcnt_d;
  logic [WIDTH-1:0] result_d, result_q;
  logic             rz_q;

  logic             accept, sgn_div, a_sgn, b_sgn, div_zero, div_ovf;
  logic [2*WIDTH-1:0] ma_c, mb_c, mprod_c, mprod_out;
  logic [2*WIDTH-1:0] mpipe_q [PD];
  logic [WIDTH-1:0] dabs_a, dabs_b, q_fix, r_fix;
  logic             div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_q, div_r;

  function automatic logic [WIDTH-1:0] mul_sel(input md_op_t op, input logic [2*WIDTH-1:0] p);
    return (op == MUL) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
  endfunction

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready && !kill;

  // Operand conditioning: signedness for the product, magnitudes for the divider.
  always_comb begin
    a_sgn    = (operator == MUL) || (operator == MULH) || (operator == MULHSU);
    b_sgn    = (operator == MUL) || (operator == MULH);
    sgn_div  = (operator == DIV) || (operator == REM);
    ma_c     = {{WIDTH{sext_bit(operand1[WIDTH-1], a_sgn)}}, operand1};
    mb_c     = {{WIDTH{sext_bit(operand2[WIDTH-1], b_sgn)}}, operand2};
    mprod_c  = ma_c * mb_c;
    dabs_a   = (sgn_div && operand1[WIDTH-1]) ? -operand1 : operand1;
    dabs_b   = (sgn_div && operand2[WIDTH-1]) ? -operand2 : operand2;
    div_zero = (operand2 == '0);
    div_ovf  = sgn_div && (operand1 == MIN_INT) && (operand2 == '1);
    q_fix    = neg_q_q ? -div_q : div_q;
    r_fix    = neg_r_q ? -div_r : div_r;
  end

  // Product pipeline; free-running, the latency counter picks the right slot.
  always_ff @(posedge clk) begin
    mpipe_q[0] <= mprod_c;
    for (int i = 1; i < PD; i++) mpipe_q[i] <= mpipe_q[i-1];
  end

  assign mprod_out = (MUL_LATENCY > 1) ? mpipe_q[PD-1] : mprod_c;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .a     (dabs_a),
    .b     (dabs_b),
    .busy  (div_busy),
    .done  (div_done),
    .q     (div_q),
    .r     (div_r)
  );

  // Next-state and result selection; kill wins over everything.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    mcnt_d    = mcnt_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        case (operator)
          MUL, MULH, MULHSU, MULHU: begin
            if (MUL_LATENCY == 1) begin
              result_d = mul_sel(operator, mprod_c);
              state_d  = ST_DONE;
            end else begin
              mcnt_d  = MCW'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);
              state_d = ST_MUL;
            end
          end
          DIV, DIVU, REM, REMU: begin
            state_d = ST_DONE;
            if (div_zero)
              result_d = (operator == DIV || operator == DIVU) ? '1 : operand1;
            else if (div_ovf)
              result_d = (operator == DIV) ? MIN_INT : '0;
            else begin
              div_start = 1'b1;
              state_d   = ST_DIV;
            end
          end
          default: begin
            result_d = '0;
            state_d  = ST_DONE;
          end
        endcase
      end
      ST_MUL: begin
        if (mcnt_q == '0) begin
          result_d = mul_sel(op_q, mprod_out);
          state_d  = ST_DONE;
        end else begin
          mcnt_d = mcnt_q - 1'b1;
        end
      end
      ST_DIV: if (div_done && !div_busy) begin
        result_d = (op_q == DIV || op_q == DIVU) ? q_fix : r_fix;
        state_d  = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (kill) begin
      state_d   = ST_IDLE;
      result_d  = result_q;
      div_start = 1'b0;
    end
  end

  // Control, latched op info, and result with its zero flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= MUL;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      mcnt_q   <= '0;
      result_q <= '0;
      rz_q     <= ALU_RESULT_IS_ZERO;
    end else begin
      state_q  <= state_d;
      mcnt_q   <= mcnt_d;
      result_q <= result_d;
      rz_q     <= (result_d == '0) ? ALU_RESULT_IS_ZERO : ALU_RESULT_IS_NOT_ZERO;
      if (accept) begin
        op_q    <= operator;
        neg_q_q <= sgn_div && (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
        neg_r_q <= sgn_div && operand1[WIDTH-1];
      end
    end
  end

  assign result         = result_q;
  assign result_is_zero = rz_q;

endmodule
